ras_recover_ctrl: RTL and testbench



---
 rtl/ras_recover_ctrl.sv | 131 +++++++++++++
 tb/tb_ras_recover_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ras_recover_ctrl.sv
// Speculative return-address-stack pointer owner: arbitrates BTB/predecode push-pop
// traffic and, after a retire mispredict, replays the committed stack into the speculative array.
module ras_recover_ctrl #(
   parameter int DEPTH = 16,
   parameter int PTRW  = 4,
   parameter int AW    = 32
) (
   input  logic            Clk,
   input  logic            Rest,
   input  logic            BtbReq,
   input  logic            BtbPush,
   input  logic [AW-1:0]   BtbData,
   input  logic            PreReq,
   input  logic            PrePush,
   input  logic [AW-1:0]   PreData,
   output logic            BtbGnt,
   output logic            PreGnt,
   input  logic            RecoverReq,
   input  logic [PTRW-1:0] RetirePtr,
   output logic            RetRdAble,
   output logic [PTRW-1:0] RetRdIdx,
   input  logic [AW-1:0]   RetRdData,
   output logic            SpecWrAble,
   output logic [PTRW-1:0] SpecWrIdx,
   output logic [AW-1:0]   SpecWrData,
   output logic [PTRW-1:0] SpecPtr,
   output logic            RasStop,
   output logic            RecoverDone
);

   typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

   state_t          state, nextState;
   logic [PTRW-1:0] specPtr, nextPtr;
   logic [PTRW-1:0] cnt, nextCnt;
   logic [PTRW-1:0] latN, nextN;
   logic            opVld, opPush;
   logic [AW-1:0]   opData;

   assign SpecPtr = specPtr;

   always_ff @(posedge Clk) begin
      if (Rest) begin
         state   <= IDLE;
         specPtr <= '0;
         cnt     <= '0;
         latN    <= '0;
      end else begin
         state   <= nextState;
         specPtr <= nextPtr;
         cnt     <= nextCnt;
         latN    <= nextN;
      end
   end

   always_comb begin
      nextState   = state;
      nextPtr     = specPtr;
      nextCnt     = cnt;
      nextN       = latN;
      BtbGnt      = 1'b0;
      PreGnt      = 1'b0;
      RetRdAble   = 1'b0;
      RetRdIdx    = '0;
      SpecWrAble  = 1'b0;
      SpecWrIdx   = '0;
      SpecWrData  = '0;
      RasStop     = 1'b0;
      RecoverDone = 1'b0;
      opVld       = 1'b0;
      opPush      = 1'b0;
      opData      = '0;
      // Outputs stay quiet during reset so no stray write or grant escapes.
      if (!Rest) begin
         case (state)
            IDLE: begin
               if (!RecoverReq) begin
                  PreGnt = PreReq;
                  BtbGnt = BtbReq & ~PreReq;
                  opVld  = PreReq | BtbReq;
                  opPush = PreReq ? PrePush : BtbPush;
                  opData = PreReq ? PreData : BtbData;
                  if (opVld && opPush) begin
                     SpecWrAble = 1'b1;
                     SpecWrIdx  = specPtr;
                     SpecWrData = opData;
                     nextPtr    = specPtr + PTRW'(1);
                  end else if (opVld) begin
                     nextPtr = specPtr - PTRW'(1);
                  end
               end
            end
            COPY: begin
               RasStop   = 1'b1;
               RetRdAble = 1'b1;
               RetRdIdx  = cnt;
               nextCnt   = cnt + PTRW'(1);
               // Data returned this cycle belongs to the read issued one cycle earlier.
               if (cnt != '0 && !RecoverReq) begin
                  SpecWrAble = 1'b1;
                  SpecWrIdx  = cnt - PTRW'(1);
                  SpecWrData = RetRdData;
               end
               if (cnt == latN - PTRW'(1))
                  nextState = DONE;
            end
            DONE: begin
               RasStop = 1'b1;
               if (!RecoverReq) begin
                  if (latN != '0) begin
                     SpecWrAble = 1'b1;
                     SpecWrIdx  = latN - PTRW'(1);
                     SpecWrData = RetRdData;
                  end
                  RecoverDone = 1'b1;
                  nextPtr     = latN;
                  nextState   = IDLE;
               end
            end
            default: nextState = IDLE;
         endcase
         // A new mispredict always (re)starts the copy from index 0.
         if (RecoverReq) begin
            nextN     = RetirePtr;
            nextCnt   = '0;
            nextState = (RetirePtr != '0) ? COPY : DONE;
         end
      end
   end

endmodule

// File: tb/tb_ras_recover_ctrl.sv
// Directed bench for ras_recover_ctrl: a cycle-schedule model checked every cycle,
// plus literal expectations for each test-plan scenario.
module tb_ras_recover_ctrl;

   logic        Clk;
   logic        Rest;
   logic        BtbReq, BtbPush, PreReq, PrePush, RecoverReq;
   logic [31:0] BtbData, PreData, RetRdData;
   logic [3:0]  RetirePtr;
   logic        BtbGnt, PreGnt, RetRdAble, SpecWrAble, RasStop, RecoverDone;
   logic [3:0]  RetRdIdx, SpecWrIdx, SpecPtr;
   logic [31:0] SpecWrData;

   ras_recover_ctrl #(.DEPTH(16), .PTRW(4), .AW(32)) dut (
      .Clk(Clk), .Rest(Rest),
      .BtbReq(BtbReq), .BtbPush(BtbPush), .BtbData(BtbData),
      .PreReq(PreReq), .PrePush(PrePush), .PreData(PreData),
      .BtbGnt(BtbGnt), .PreGnt(PreGnt),
      .RecoverReq(RecoverReq), .RetirePtr(RetirePtr),
      .RetRdAble(RetRdAble), .RetRdIdx(RetRdIdx), .RetRdData(RetRdData),
      .SpecWrAble(SpecWrAble), .SpecWrIdx(SpecWrIdx), .SpecWrData(SpecWrData),
      .SpecPtr(SpecPtr), .RasStop(RasStop), .RecoverDone(RecoverDone)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Committed stack: one-cycle read latency.
   logic [31:0] commit [16];
   logic [31:0] retData;
   always @(posedge Clk) if (RetRdAble) retData <= commit[RetRdIdx];
   assign RetRdData = retData;

   // Model: mRecCyc = cycles since a recovery was accepted (0 = not recovering).
   int mPtr = 0, mRecCyc = 0, mRecN = 0;
   always @(posedge Clk) begin
      if (Rest) begin
         mPtr <= 0; mRecCyc <= 0; mRecN <= 0;
      end else if (RecoverReq) begin
         mRecN <= int'(RetirePtr); mRecCyc <= 1;
      end else if (mRecCyc != 0) begin
         if (mRecCyc == mRecN + 1) begin mPtr <= mRecN; mRecCyc <= 0; end
         else mRecCyc <= mRecCyc + 1;
      end else if (PreReq) begin
         mPtr <= PrePush ? (mPtr + 1) % 16 : (mPtr + 15) % 16;
      end else if (BtbReq) begin
         mPtr <= BtbPush ? (mPtr + 1) % 16 : (mPtr + 15) % 16;
      end
   end

   logic        eBtbGnt, ePreGnt, eRd, eWr, eStop, eDone;
   logic [3:0]  eRdIdx, eWrIdx;
   logic [31:0] eWrData;
   always_comb begin
      eBtbGnt = 1'b0; ePreGnt = 1'b0; eRd = 1'b0; eWr = 1'b0; eStop = 1'b0; eDone = 1'b0;
      eRdIdx = '0; eWrIdx = '0; eWrData = '0;
      if (mRecCyc == 0) begin
         if (!RecoverReq) begin
            ePreGnt = PreReq;
            eBtbGnt = BtbReq && !PreReq;
            if (PreReq ? PrePush : (BtbReq && BtbPush)) begin
               eWr = 1'b1; eWrIdx = mPtr[3:0]; eWrData = PreReq ? PreData : BtbData;
            end
         end
      end else begin
         eStop = 1'b1;
         if (mRecCyc <= mRecN) begin eRd = 1'b1; eRdIdx = 4'(mRecCyc - 1); end
         if (!RecoverReq) begin
            if (mRecCyc >= 2) begin
               eWr = 1'b1; eWrIdx = 4'(mRecCyc - 2); eWrData = commit[4'(mRecCyc - 2)];
            end
            eDone = (mRecCyc == mRecN + 1);
         end
      end
   end

   int total = 0, bad = 0;
   int cyc = 0, stallCnt = 0, doneCnt = 0, wrCnt = 0, gntStall = 0, doneCyc = 0;
   logic        lastBtbGnt, lastPreGnt, lastWr;
   logic [31:0] wrLog [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h at cyc %0d", name, act, exp, cyc);
      end
   endtask

   // Observe one cycle at the falling edge, then step past the next rising edge.
   task automatic tick();
      @(negedge Clk);
      if (!Rest) begin
         chk("BtbGnt", BtbGnt, eBtbGnt);
         chk("PreGnt", PreGnt, ePreGnt);
         chk("RasStop", RasStop, eStop);
         chk("RecoverDone", RecoverDone, eDone);
         chk("RetRdAble", RetRdAble, eRd);
         chk("SpecWrAble", SpecWrAble, eWr);
         chk("SpecPtr", SpecPtr, mPtr[3:0]);
         if (eRd) chk("RetRdIdx", RetRdIdx, eRdIdx);
         if (eWr) begin
            chk("SpecWrIdx", SpecWrIdx, eWrIdx);
            chk("SpecWrData", SpecWrData, eWrData);
         end
      end
      if (SpecWrAble) begin wrLog[SpecWrIdx] = SpecWrData; wrCnt++; end
      stallCnt += int'(RasStop);
      doneCnt  += int'(RecoverDone);
      if (RecoverDone) doneCyc = cyc;
      if (RasStop && (BtbGnt || PreGnt)) gntStall++;
      lastBtbGnt = BtbGnt; lastPreGnt = PreGnt; lastWr = SpecWrAble;
      cyc++;
      @(posedge Clk); #1;
   endtask

   task automatic quiet();
      BtbReq = 0; BtbPush = 0; BtbData = '0;
      PreReq = 0; PrePush = 0; PreData = '0;
      RecoverReq = 0; RetirePtr = '0;
   endtask

   int s0, d0, w0, w1, g0, c0;

   initial begin
      Rest = 1'b1;
      quiet();
      for (int i = 0; i < 16; i++) begin commit[i] = '0; wrLog[i] = '0; end
      repeat (3) tick();
      Rest = 1'b0;
      tick(); tick();
      chk("rst_ptr", SpecPtr, 0);
      chk("rst_wr", lastWr, 0);

      // Three BTB pushes, then a pop
      BtbReq = 1; BtbPush = 1;
      BtbData = 32'h1000; tick();
      BtbData = 32'h1004; tick();
      BtbData = 32'h1008; tick();
      quiet();
      chk("push_ptr", SpecPtr, 3);
      chk("push_w0", wrLog[0], 32'h1000);
      chk("push_w1", wrLog[1], 32'h1004);
      chk("push_w2", wrLog[2], 32'h1008);
      BtbReq = 1; BtbPush = 0; tick(); quiet();
      chk("pop_ptr", SpecPtr, 2);
      chk("pop_nowr", lastWr, 0);

      // Predecode pop beats BTB push
      BtbReq = 1; BtbPush = 1; BtbData = 32'hA0; PreReq = 1; PrePush = 0;
      tick(); quiet();
      chk("arb_pregnt", lastPreGnt, 1);
      chk("arb_btbgnt", lastBtbGnt, 0);
      chk("arb_nowr", lastWr, 0);
      chk("arb_ptr", SpecPtr, 1);

      // Recovery N=3 with requests held during the stall
      commit[0] = 32'h10; commit[1] = 32'h20; commit[2] = 32'h30;
      s0 = stallCnt; d0 = doneCnt; w0 = wrCnt; g0 = gntStall; c0 = cyc;
      RecoverReq = 1; RetirePtr = 4'd3; tick(); quiet();
      BtbReq = 1; BtbPush = 1; BtbData = 32'hBAD0; PreReq = 1; PrePush = 1; PreData = 32'hBAD1;
      repeat (4) tick();
      quiet();
      chk("rec3_stall", stallCnt - s0, 4);
      chk("rec3_done", doneCnt - d0, 1);
      chk("rec3_donecyc", doneCyc - c0, 4);
      chk("rec3_wrcnt", wrCnt - w0, 3);
      chk("rec3_nogrant", gntStall - g0, 0);
      chk("rec3_w0", wrLog[0], 32'h10);
      chk("rec3_w1", wrLog[1], 32'h20);
      chk("rec3_w2", wrLog[2], 32'h30);
      chk("rec3_ptr", SpecPtr, 3);

      // Recovery N=0
      s0 = stallCnt; d0 = doneCnt; w0 = wrCnt;
      RecoverReq = 1; RetirePtr = 4'd0; tick(); quiet();
      tick();
      chk("rec0_stall", stallCnt - s0, 1);
      chk("rec0_done", doneCnt - d0, 1);
      chk("rec0_wrcnt", wrCnt - w0, 0);
      chk("rec0_ptr", SpecPtr, 0);

      // Wrap both ways
      BtbReq = 1; BtbPush = 0; tick(); quiet();
      chk("wrap_pop", SpecPtr, 15);
      PreReq = 1; PrePush = 1; PreData = 32'hF00D; tick(); quiet();
      chk("wrap_push", SpecPtr, 0);
      chk("wrap_w15", wrLog[15], 32'hF00D);

      // Recovery N=5 restarted in its third copy cycle with N=2
      for (int i = 0; i < 5; i++) commit[i] = 32'hC0DE0000 + 32'(i);
      d0 = doneCnt;
      RecoverReq = 1; RetirePtr = 4'd5; tick(); quiet();
      tick(); tick();
      w0 = wrCnt;
      RecoverReq = 1; RetirePtr = 4'd2; tick(); quiet();
      w1 = wrCnt;
      chk("rst_drop_wr", w1 - w0, 0);
      repeat (3) tick();
      chk("rst_wrcnt", wrCnt - w1, 2);
      chk("rst_w0", wrLog[0], 32'hC0DE0000);
      chk("rst_w1", wrLog[1], 32'hC0DE0001);
      chk("rst_w2_kept", wrLog[2], 32'h30);
      chk("rst_done", doneCnt - d0, 1);
      chk("rst_ptr2", SpecPtr, 2);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
